// File: rtl/midi_msg_tx.sv
// MIDI message transmitter: buffers complete messages, applies running-status
// compression, slots realtime bytes in at byte boundaries and sends 8N1 serial.
module midi_msg_tx #(
    parameter int CLK_HZ     = 50000000,
    parameter int BAUD       = 31250,
    parameter int FIFO_DEPTH = 4,
    parameter int RS_EN      = 1,
    parameter int RS_TIMEOUT = 12500000
) (
    input  logic       CLOCK_50,
    input  logic       reset_reg_N,
    input  logic       msg_valid,
    output logic       msg_ready,
    input  logic [7:0] msg_status,
    input  logic [6:0] msg_data1,
    input  logic [6:0] msg_data2,
    input  logic       rt_valid,
    input  logic [7:0] rt_byte,
    output logic       rt_ready,
    output logic       midi_txd,
    output logic       byte_sent,
    output logic       drop_err,
    output logic       busy
);
    localparam int BIT_CYCLES = CLK_HZ / BAUD;
    localparam int CW = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int TW = $clog2(RS_TIMEOUT + 1);
    localparam logic [CW-1:0] BIT_LAST = CW'(BIT_CYCLES - 1);
    localparam logic [TW-1:0] TO_LAST  = TW'(RS_TIMEOUT - 1);
    localparam logic [TW-1:0] TO_MAX   = TW'(RS_TIMEOUT);
    localparam logic [AW:0]   FIFO_MAX = (AW + 1)'(FIFO_DEPTH);

    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_STAT, S_D1, S_D2} state_t;

    function automatic logic [1:0] msg_len(input logic [7:0] s);
        logic [1:0] len;
        case (s[7:4])
            4'h8, 4'h9, 4'hA, 4'hB, 4'hE: len = 2'd3;
            4'hC, 4'hD:                   len = 2'd2;
            4'hF: len = (s == 8'hF2) ? 2'd3 : ((s == 8'hF1 || s == 8'hF3) ? 2'd2 : 2'd1);
            default:                      len = 2'd1;
        endcase
        return len;
    endfunction

    logic [21:0]   fifo_mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_reg, rd_ptr_reg;
    logic [AW:0]   fifo_count_reg;
    state_t        state_reg, state_next, seq_state;
    logic [7:0]    cur_status_reg, last_status_reg, last_status_next;
    logic [6:0]    cur_d1_reg, cur_d2_reg;
    logic          rt_full_reg, drop_err_reg;
    logic [7:0]    rt_byte_reg;
    logic [TW-1:0] idle_cnt_reg;
    logic          ser_active_reg;
    logic [9:0]    frame_reg;
    logic [3:0]    bit_idx_reg;
    logic [CW-1:0] cyc_cnt_reg;

    logic       msg_take, push, pop, rt_take, rt_bad, rt_store, rt_send;
    logic       load, frame_done, ser_ready, rs_skip, idle_now;
    logic [7:0] load_byte, sel_status;
    logic [6:0] sel_d1, sel_d2;
    logic [1:0] sel_len;

    assign msg_ready  = (fifo_count_reg != FIFO_MAX);
    assign msg_take   = msg_valid && msg_ready;
    assign push       = msg_take && msg_status[7];
    assign rt_ready   = !rt_full_reg;
    assign rt_take    = rt_valid && rt_ready;
    assign rt_bad     = rt_take && (rt_byte < 8'hF8);
    assign rt_store   = rt_take && !rt_bad;
    assign frame_done = ser_active_reg && (bit_idx_reg == 4'd9) && (cyc_cnt_reg == BIT_LAST);
    // A new frame may be loaded on the last stop-bit cycle so frames abut.
    assign ser_ready  = !ser_active_reg || frame_done;
    assign midi_txd   = ser_active_reg ? frame_reg[0] : 1'b1;
    assign byte_sent  = frame_done;
    assign drop_err   = drop_err_reg;
    assign busy       = (fifo_count_reg != '0) || (state_reg != S_IDLE) || ser_active_reg || rt_full_reg;

    // In LOAD the FIFO head is used directly so the first byte leaves without an extra cycle.
    assign sel_status = (state_reg == S_LOAD) ? fifo_mem[rd_ptr_reg][21:14] : cur_status_reg;
    assign sel_d1     = (state_reg == S_LOAD) ? fifo_mem[rd_ptr_reg][13:7]  : cur_d1_reg;
    assign sel_d2     = (state_reg == S_LOAD) ? fifo_mem[rd_ptr_reg][6:0]   : cur_d2_reg;
    assign sel_len    = msg_len(sel_status);
    assign rs_skip    = (RS_EN != 0) && (sel_status >= 8'h80) && (sel_status <= 8'hEF) &&
                        (sel_status == last_status_reg);

    always_comb begin
        state_next       = state_reg;
        seq_state        = state_reg;
        pop              = 1'b0;
        load             = 1'b0;
        load_byte        = 8'h00;
        rt_send          = 1'b0;
        last_status_next = last_status_reg;
        case (state_reg)
            S_IDLE: if (fifo_count_reg != '0 || push) state_next = S_LOAD;
            S_LOAD: begin
                pop        = 1'b1;
                seq_state  = rs_skip ? S_D1 : S_STAT;
                state_next = seq_state;
            end
            default: ;
        endcase
        if (ser_ready) begin
            if (rt_full_reg) begin
                load      = 1'b1;
                load_byte = rt_byte_reg;
                rt_send   = 1'b1;
            end else begin
                case (seq_state)
                    S_STAT: begin
                        load       = 1'b1;
                        load_byte  = sel_status;
                        state_next = (sel_len > 2'd1) ? S_D1 : S_IDLE;
                        if (sel_status <= 8'hEF)      last_status_next = sel_status;
                        else if (sel_status < 8'hF8)  last_status_next = 8'h00;
                    end
                    S_D1: begin
                        load       = 1'b1;
                        load_byte  = {1'b0, sel_d1};
                        state_next = (sel_len > 2'd2) ? S_D2 : S_IDLE;
                    end
                    S_D2: begin
                        load       = 1'b1;
                        load_byte  = {1'b0, sel_d2};
                        state_next = S_IDLE;
                    end
                    default: ;
                endcase
            end
        end
        idle_now = !ser_active_reg && !load;
        if (idle_now && idle_cnt_reg == TO_LAST) last_status_next = 8'h00;
    end

    always_ff @(posedge CLOCK_50) begin
        if (push) fifo_mem[wr_ptr_reg] <= {msg_status, msg_data1, msg_data2};
    end

    always_ff @(posedge CLOCK_50 or negedge reset_reg_N) begin
        if (!reset_reg_N) begin
            wr_ptr_reg      <= '0;
            rd_ptr_reg      <= '0;
            fifo_count_reg  <= '0;
            state_reg       <= S_IDLE;
            cur_status_reg  <= 8'h00;
            cur_d1_reg      <= 7'h00;
            cur_d2_reg      <= 7'h00;
            last_status_reg <= 8'h00;
            rt_full_reg     <= 1'b0;
            rt_byte_reg     <= 8'h00;
            drop_err_reg    <= 1'b0;
            idle_cnt_reg    <= '0;
            ser_active_reg  <= 1'b0;
            frame_reg       <= 10'h3FF;
            bit_idx_reg     <= 4'd0;
            cyc_cnt_reg     <= '0;
        end else begin
            state_reg       <= state_next;
            last_status_reg <= last_status_next;
            drop_err_reg    <= (msg_take && !msg_status[7]) || rt_bad;
            if (push) wr_ptr_reg <= wr_ptr_reg + AW'(1);
            if (pop) begin
                rd_ptr_reg     <= rd_ptr_reg + AW'(1);
                cur_status_reg <= sel_status;
                cur_d1_reg     <= sel_d1;
                cur_d2_reg     <= sel_d2;
            end
            case ({push, pop})
                2'b10:   fifo_count_reg <= fifo_count_reg + (AW + 1)'(1);
                2'b01:   fifo_count_reg <= fifo_count_reg - (AW + 1)'(1);
                default: ;
            endcase
            if (rt_store) begin
                rt_full_reg <= 1'b1;
                rt_byte_reg <= rt_byte;
            end else if (rt_send) begin
                rt_full_reg <= 1'b0;
            end
            if (!idle_now)                 idle_cnt_reg <= '0;
            else if (idle_cnt_reg < TO_MAX) idle_cnt_reg <= idle_cnt_reg + TW'(1);
            if (load) begin
                ser_active_reg <= 1'b1;
                frame_reg      <= {1'b1, load_byte, 1'b0};
                bit_idx_reg    <= 4'd0;
                cyc_cnt_reg    <= '0;
            end else if (ser_active_reg) begin
                if (cyc_cnt_reg == BIT_LAST) begin
                    cyc_cnt_reg <= '0;
                    if (bit_idx_reg == 4'd9) begin
                        ser_active_reg <= 1'b0;
                    end else begin
                        bit_idx_reg <= bit_idx_reg + 4'd1;
                        frame_reg   <= {1'b1, frame_reg[9:1]};
                    end
                end else begin
                    cyc_cnt_reg <= cyc_cnt_reg + CW'(1);
                end
            end
        end
    end
endmodule

// File: tb/tb_midi_msg_tx.sv
// Directed bench for midi_msg_tx with a scaled baud (16 cycles/bit, 160/frame).
module tb_midi_msg_tx;
    localparam int BIT   = 16;
    localparam int RS_TO = 500;

    logic       clk = 1'b0, rst_n = 1'b0;
    logic       msg_valid = 1'b0, rt_valid = 1'b0;
    logic [7:0] msg_status = 8'h00, rt_byte = 8'h00;
    logic [6:0] msg_data1 = 7'h00, msg_data2 = 7'h00;
    logic       msg_ready, rt_ready, midi_txd, byte_sent, drop_err, busy;

    midi_msg_tx #(.CLK_HZ(160), .BAUD(10), .FIFO_DEPTH(4), .RS_EN(1), .RS_TIMEOUT(RS_TO)) dut (
        .CLOCK_50(clk), .reset_reg_N(rst_n),
        .msg_valid(msg_valid), .msg_ready(msg_ready), .msg_status(msg_status),
        .msg_data1(msg_data1), .msg_data2(msg_data2),
        .rt_valid(rt_valid), .rt_byte(rt_byte), .rt_ready(rt_ready),
        .midi_txd(midi_txd), .byte_sent(byte_sent), .drop_err(drop_err), .busy(busy)
    );

    always #5 clk = ~clk;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_vec = 0, n_err = 0;
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Line monitor: decodes frames mid-bit, logs start cycles and byte_sent pulses.
    logic [7:0] rx_q[$];
    int         rx_t[$];
    int         bs_t[$];
    int         drop_cnt = 0, ferr = 0, mon_off = 0;
    logic       mon_act = 1'b0;
    logic [9:0] mon_bits = '0;
    always @(negedge clk) begin
        if (!rst_n) begin
            mon_act = 1'b0;
        end else begin
            if (byte_sent) bs_t.push_back(cyc);
            if (drop_err) drop_cnt++;
            if (!mon_act) begin
                if (!midi_txd) begin
                    mon_act = 1'b1;
                    mon_off = 0;
                    rx_t.push_back(cyc);
                end
            end else begin
                mon_off++;
                if (mon_off % BIT == BIT / 2) begin
                    mon_bits[mon_off / BIT] = midi_txd;
                    if (mon_off / BIT == 9) begin
                        rx_q.push_back(mon_bits[8:1]);
                        if (mon_bits[0] || !mon_bits[9]) ferr++;
                        mon_act = 1'b0;
                    end
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic clear_rx();
        rx_q.delete();
        rx_t.delete();
        bs_t.delete();
    endtask

    task automatic send_msg(input logic [7:0] s, input logic [6:0] a, input logic [6:0] b, output int acc);
        int t;
        acc = -1;
        msg_status = s; msg_data1 = a; msg_data2 = b; msg_valid = 1'b1;
        for (t = 0; t < 2000; t++) begin
            if (msg_ready) begin
                acc = cyc;
                break;
            end
            @(negedge clk);
        end
        @(negedge clk);
        msg_valid = 1'b0;
        chk("msg_taken", acc >= 0, 1);
        $display("msg %02h %02h %02h accepted at cycle %0d", s, a, b, acc);
    endtask

    task automatic send_rt(input logic [7:0] v, output int acc);
        int t;
        acc = -1;
        rt_byte = v; rt_valid = 1'b1;
        for (t = 0; t < 2000; t++) begin
            if (rt_ready) begin
                acc = cyc;
                break;
            end
            @(negedge clk);
        end
        @(negedge clk);
        rt_valid = 1'b0;
        chk("rt_taken", acc >= 0, 1);
        $display("rt %02h accepted at cycle %0d", v, acc);
    endtask

    task automatic wait_idle(output int t_idle);
        for (int t = 0; t < 5000; t++) begin
            if (!busy) break;
            @(negedge clk);
        end
        t_idle = cyc;
        chk("busy_drop", busy, 0);
    endtask

    logic [7:0] exp_q[$];
    task automatic check_rx(input string tag);
        chk({tag, "_count"}, rx_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size(); i++)
            chk($sformatf("%s_b%0d", tag, i), (i < rx_q.size()) ? rx_q[i] : 8'hXX, exp_q[i]);
    endtask

    logic [7:0] t5_st [6] = '{8'h80, 8'h80, 8'hC0, 8'hC0, 8'hE1, 8'hF6};
    logic [6:0] t5_a  [6] = '{7'h01, 7'h03, 7'h05, 7'h06, 7'h07, 7'h00};
    logic [6:0] t5_b  [6] = '{7'h02, 7'h04, 7'h00, 7'h00, 7'h08, 7'h00};

    initial begin
        int n, s, a, b, ti, d0;
        int acc5 [6];
        tick(3);
        chk("rst_txd", midi_txd, 1);
        chk("rst_msg_ready", msg_ready, 1);
        chk("rst_rt_ready", rt_ready, 1);
        chk("rst_byte_sent", byte_sent, 0);
        chk("rst_drop_err", drop_err, 0);
        chk("rst_busy", busy, 0);
        rst_n = 1'b1;
        tick(3);
        chk("post_rst_txd", midi_txd, 1);

        // 1: plain 3-byte message, latency and bit timing
        clear_rx();
        send_msg(8'h90, 7'h3C, 7'h64, n);
        chk("t1_pre_start", midi_txd, 1);
        tick(1);
        chk("t1_start", midi_txd, 0);
        s = n + 2;
        tick(s + 79 - cyc); chk("t1_bit3", midi_txd, 0);
        tick(1);            chk("t1_bit4_first", midi_txd, 1);
        tick(15);           chk("t1_bit4_last", midi_txd, 1);
        tick(1);            chk("t1_bit5", midi_txd, 0);
        wait_idle(ti);
        chk("t1_busy_drop_cyc", ti, s + 480);
        tick(2);
        exp_q = '{8'h90, 8'h3C, 8'h64};
        check_rx("t1");
        chk("t1_gap01", rx_t[1] - rx_t[0], 160);
        chk("t1_gap12", rx_t[2] - rx_t[1], 160);
        chk("t1_bs_count", bs_t.size(), 3);
        chk("t1_bs0_cyc", bs_t[0], s + 159);
        chk("t1_bs_gap01", bs_t[1] - bs_t[0], 160);
        chk("t1_bs_gap12", bs_t[2] - bs_t[1], 160);

        // 2: running status within and beyond the timeout
        clear_rx();
        send_msg(8'h90, 7'h40, 7'h7F, n);
        wait_idle(ti); tick(2);
        exp_q = '{8'h40, 8'h7F};
        check_rx("t2_rs");
        clear_rx();
        tick(RS_TO + 50);
        send_msg(8'h90, 7'h41, 7'h7F, n);
        wait_idle(ti); tick(2);
        exp_q = '{8'h90, 8'h41, 8'h7F};
        check_rx("t2_to");

        // 3: 2-byte program change, msg-path realtime keeps running status
        clear_rx();
        send_msg(8'hC5, 7'h10, 7'h55, n);
        send_msg(8'hF8, 7'h00, 7'h00, n);
        send_msg(8'hC5, 7'h11, 7'h00, n);
        wait_idle(ti); tick(2);
        exp_q = '{8'hC5, 8'h10, 8'hF8, 8'h11};
        check_rx("t3");

        // 4: realtime inserted during the status frame, second rt waits
        clear_rx();
        send_msg(8'h90, 7'h3C, 7'h64, n);
        s = n + 2;
        tick(s + 40 - cyc);
        send_rt(8'hF8, a);
        chk("t4_rt_ready_low", rt_ready, 0);
        send_rt(8'hF9, b);
        chk("t4_rt2_accept_cyc", b, s + 160);
        wait_idle(ti); tick(2);
        exp_q = '{8'h90, 8'hF8, 8'hF9, 8'h3C, 8'h64};
        check_rx("t4");
        chk("t4_rt_start_cyc", rx_t[1], s + 160);

        // 5: FIFO fill, ordering, drops, rt latency
        clear_rx();
        for (int i = 0; i < 6; i++) begin
            send_msg(t5_st[i], t5_a[i], t5_b[i], acc5[i]);
            if (i == 4) chk("t5_full_ready", msg_ready, 0);
        end
        chk("t5_acc4", acc5[4], acc5[0] + 4);
        chk("t5_acc5", acc5[5], acc5[0] + 324);
        wait_idle(ti); tick(2);
        exp_q = '{8'h80, 8'h01, 8'h02, 8'h03, 8'h04, 8'hC0, 8'h05, 8'h06,
                  8'hE1, 8'h07, 8'h08, 8'hF6};
        check_rx("t5");
        d0 = drop_cnt;
        send_msg(8'h3C, 7'h01, 7'h02, a);
        chk("t5_drop_pulse", drop_err, 1);
        tick(1);
        chk("t5_drop_one_cycle", drop_err, 0);
        chk("t5_drop_busy", busy, 0);
        send_rt(8'h42, a);
        chk("t5_rt_drop_pulse", drop_err, 1);
        tick(200);
        chk("t5_drop_count", drop_cnt - d0, 2);
        chk("t5_no_frame", rx_q.size(), 12);
        send_rt(8'hFE, a);
        chk("t5_rt_pre_start", midi_txd, 1);
        tick(1);
        chk("t5_rt_start", midi_txd, 0);
        wait_idle(ti); tick(2);
        chk("t5_rt_byte", rx_q[12], 8'hFE);

        // 6: asynchronous reset mid data bit
        send_msg(8'h90, 7'h3C, 7'h64, n);
        wait_idle(ti); tick(2);
        clear_rx();
        send_msg(8'h90, 7'h11, 7'h22, n);
        send_msg(8'h90, 7'h33, 7'h44, a);
        s = n + 2;
        tick(s + 50 - cyc);
        chk("t6_pre_rst_txd", midi_txd, 0);
        #3 rst_n = 1'b0;
        #1;
        chk("t6_rst_txd", midi_txd, 1);
        chk("t6_rst_busy", busy, 0);
        chk("t6_rst_msg_ready", msg_ready, 1);
        tick(3);
        rst_n = 1'b1;
        clear_rx();
        tick(300);
        chk("t6_flushed", rx_q.size(), 0);
        send_msg(8'h90, 7'h55, 7'h66, n);
        wait_idle(ti); tick(2);
        exp_q = '{8'h90, 8'h55, 8'h66};
        check_rx("t6");

        chk("framing", ferr, 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #(10 * 60000);
        $display("FAIL watchdog: bench did not finish, applied %0d", n_vec);
        $fatal(1);
    end
endmodule
